// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM stage of a 5-stage pipeline plus the MEM/WB pipeline register.
//   Issues one data-memory access per instruction, stalls the front of
//   the pipeline while the memory is slow, and aborts an access (setting a
//   sticky error flag) if it waits too long.
//
// Parameters
//   TIMEOUT : maximum wait cycles per access (2..255)
//
// Ports
//   clk, reset (async, active-low)
//   MEM_*_In                 : fields from the EX/MEM pipeline register
//   mem_req/we/addr/wdata    : data-memory request (combinational)
//   mem_rdata, mem_ready     : data-memory response
//   stall                    : hold PC, IF/ID, ID/EX and EX/MEM
//   PCSrc                    : branch taken
//   mem_err                  : sticky timeout flag
//   WB_*_Out                 : registered MEM/WB fields
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemWrite_In,
  input  logic        MEM_MemRead_In,
  input  logic        MEM_MemtoReg_In,
  input  logic        MEM_RegWrite_In,
  input  logic        MEM_Zero_In,
  input  logic [1:0]  MEM_Branch_In,
  input  logic [31:0] MEM_ALUresult_In,
  input  logic [31:0] MEM_ReadData2_In,
  input  logic [4:0]  MEM_WriteRegister_In,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic        PCSrc,
  output logic        mem_err,
  output logic        WB_RegWrite_Out,
  output logic        WB_MemtoReg_Out,
  output logic [31:0] WB_ReadData_Out,
  output logic [31:0] WB_ALUresult_Out,
  output logic [4:0]  WB_WriteRegister_Out
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] LP_WCNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wcnt;
  logic [7:0]  w_wcnt_next;
  logic        r_mem_err;
  logic        w_pending;
  logic        w_abort;
  logic        w_stall;
  logic        w_rd_done;

  logic        r_wb_regwrite;
  logic        r_wb_memtoreg;
  logic [31:0] r_wb_readdata;
  logic [31:0] r_wb_aluresult;
  logic [4:0]  r_wb_writereg;

  // Gating with reset keeps mem_req and stall low while reset is asserted.
  assign w_pending = reset & (MEM_MemRead_In | MEM_MemWrite_In) & ~r_mem_err;

  // Read-and-write together is treated as a write, so no read data returns.
  assign w_rd_done = w_pending & ~MEM_MemWrite_In & mem_ready;

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A ready memory completes in IDLE without ever entering WAIT.
        if (w_pending && !mem_ready) begin
          w_state_next = S_WAIT;
          w_wcnt_next  = 8'd1;
        end
      end
      S_WAIT: begin
        if (!w_pending || mem_ready) begin
          w_state_next = S_IDLE;
          w_wcnt_next  = 8'd0;
        end else if (r_wcnt == LP_WCNT_LAST) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
          w_wcnt_next  = 8'd0;
        end else begin
          w_wcnt_next  = r_wcnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_wcnt_next  = 8'd0;
      end
    endcase
  end

  // The abort cycle releases the stall so the dead instruction leaves.
  assign w_stall = w_pending & ~mem_ready & ~w_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wcnt    <= 8'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // A stalled or aborted instruction loads a bubble so it writes back once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_readdata  <= 32'd0;
      r_wb_aluresult <= 32'd0;
      r_wb_writereg  <= 5'd0;
    end else if (w_stall || w_abort) begin
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_wb_readdata  <= 32'd0;
      r_wb_aluresult <= 32'd0;
      r_wb_writereg  <= 5'd0;
    end else begin
      r_wb_regwrite  <= MEM_RegWrite_In;
      r_wb_memtoreg  <= MEM_MemtoReg_In;
      r_wb_readdata  <= w_rd_done ? mem_rdata : 32'd0;
      r_wb_aluresult <= MEM_ALUresult_In;
      r_wb_writereg  <= MEM_WriteRegister_In;
    end
  end

  assign mem_req   = w_pending;
  assign mem_we    = MEM_MemWrite_In;
  assign mem_addr  = MEM_ALUresult_In;
  assign mem_wdata = MEM_ReadData2_In;
  assign stall     = w_stall;
  assign PCSrc     = ((MEM_Branch_In == 2'b01) &  MEM_Zero_In) |
                     ((MEM_Branch_In == 2'b10) & ~MEM_Zero_In);
  assign mem_err   = r_mem_err;

  assign WB_RegWrite_Out      = r_wb_regwrite;
  assign WB_MemtoReg_Out      = r_wb_memtoreg;
  assign WB_ReadData_Out      = r_wb_readdata;
  assign WB_ALUresult_Out     = r_wb_aluresult;
  assign WB_WriteRegister_Out = r_wb_writereg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage: directed scenarios plus random
//   instruction streams, compared cycle by cycle against a behavioural model
//   that tracks "cycles already waited" and a sticky error bit.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_MemWrite_In, MEM_MemRead_In, MEM_MemtoReg_In;
  logic        MEM_RegWrite_In, MEM_Zero_In;
  logic [1:0]  MEM_Branch_In;
  logic [31:0] MEM_ALUresult_In, MEM_ReadData2_In;
  logic [4:0]  MEM_WriteRegister_In;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, stall, PCSrc, mem_err;
  logic        WB_RegWrite_Out, WB_MemtoReg_Out;
  logic [31:0] WB_ReadData_Out, WB_ALUresult_Out;
  logic [4:0]  WB_WriteRegister_Out;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .MEM_MemWrite_In      (MEM_MemWrite_In),
    .MEM_MemRead_In       (MEM_MemRead_In),
    .MEM_MemtoReg_In      (MEM_MemtoReg_In),
    .MEM_RegWrite_In      (MEM_RegWrite_In),
    .MEM_Zero_In          (MEM_Zero_In),
    .MEM_Branch_In        (MEM_Branch_In),
    .MEM_ALUresult_In     (MEM_ALUresult_In),
    .MEM_ReadData2_In     (MEM_ReadData2_In),
    .MEM_WriteRegister_In (MEM_WriteRegister_In),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ready            (mem_ready),
    .stall                (stall),
    .PCSrc                (PCSrc),
    .mem_err              (mem_err),
    .WB_RegWrite_Out      (WB_RegWrite_Out),
    .WB_MemtoReg_Out      (WB_MemtoReg_Out),
    .WB_ReadData_Out      (WB_ReadData_Out),
    .WB_ALUresult_Out     (WB_ALUresult_Out),
    .WB_WriteRegister_Out (WB_WriteRegister_Out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          m_err;
  int          m_waited;     // cycles the current access has already stalled
  logic        m_rw, m_m2r;
  logic [31:0] m_rdat, m_alu;
  logic [4:0]  m_wreg;
  bit          e_stall;
  int          stall_seen;

  task automatic m_reset();
    m_err = 0; m_waited = 0;
    m_rw = 0; m_m2r = 0; m_rdat = 0; m_alu = 0; m_wreg = 0;
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "_wb_rw"},   32'(WB_RegWrite_Out),      32'(m_rw));
    chk({tag, "_wb_m2r"},  32'(WB_MemtoReg_Out),      32'(m_m2r));
    chk({tag, "_wb_rd"},   WB_ReadData_Out,           m_rdat);
    chk({tag, "_wb_alu"},  WB_ALUresult_Out,          m_alu);
    chk({tag, "_wb_wreg"}, 32'(WB_WriteRegister_Out), 32'(m_wreg));
  endtask

  // One clock cycle: inputs already applied just after a falling edge.
  task automatic do_cycle(input string tag);
    bit   pend, abort_now, pc;
    #1;
    pend      = (MEM_MemRead_In || MEM_MemWrite_In) && !m_err;
    abort_now = pend && !mem_ready && (m_waited == TIMEOUT - 1);
    e_stall   = pend && !mem_ready && !abort_now;
    pc        = (MEM_Branch_In == 2'b01 && MEM_Zero_In) ||
                (MEM_Branch_In == 2'b10 && !MEM_Zero_In);
    chk({tag, "_req"},   32'(mem_req),  32'(pend));
    chk({tag, "_stall"}, 32'(stall),    32'(e_stall));
    chk({tag, "_we"},    32'(mem_we),   32'(MEM_MemWrite_In));
    chk({tag, "_addr"},  mem_addr,      MEM_ALUresult_In);
    chk({tag, "_wdata"}, mem_wdata,     MEM_ReadData2_In);
    chk({tag, "_pcsrc"}, 32'(PCSrc),    32'(pc));
    chk({tag, "_err"},   32'(mem_err),  32'(m_err));
    if (stall === 1'b1) stall_seen++;
    if (abort_now) begin
      m_err = 1; m_waited = 0;
      m_rw = 0; m_m2r = 0; m_rdat = 0; m_alu = 0; m_wreg = 0;
    end else if (e_stall) begin
      m_waited++;
      m_rw = 0; m_m2r = 0; m_rdat = 0; m_alu = 0; m_wreg = 0;
    end else begin
      m_waited = 0;
      m_rw   = MEM_RegWrite_In;
      m_m2r  = MEM_MemtoReg_In;
      m_alu  = MEM_ALUresult_In;
      m_wreg = MEM_WriteRegister_In;
      m_rdat = (pend && !MEM_MemWrite_In && mem_ready) ? mem_rdata : 32'd0;
    end
    @(posedge clk);
    #1;
    chk_wb(tag);
    chk({tag, "_err_q"}, 32'(mem_err), 32'(m_err));
    $display("txn %s rd=%0b wr=%0b rdy=%0b stall=%0b wb_rw=%0b wb_data=%h",
             tag, MEM_MemRead_In, MEM_MemWrite_In, mem_ready, e_stall,
             WB_RegWrite_Out, WB_ReadData_Out);
    @(negedge clk);
  endtask

  // Present one instruction and hold it while the model says it is stalled.
  task automatic run_instr(input string tag, input logic rd, input logic wr,
                           input logic m2r, input logic rw, input logic z,
                           input logic [1:0] br, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] wreg,
                           input int waits, input logic [31:0] rdat);
    bit done;
    MEM_MemRead_In = rd; MEM_MemWrite_In = wr; MEM_MemtoReg_In = m2r;
    MEM_RegWrite_In = rw; MEM_Zero_In = z; MEM_Branch_In = br;
    MEM_ALUresult_In = alu; MEM_ReadData2_In = wd; MEM_WriteRegister_In = wreg;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rdat : $urandom;
      do_cycle(tag);
      if (!e_stall) done = 1;
    end
    if (!done) chk({tag, "_wait_bound"}, 32'd0, 32'd1);
  endtask

  initial begin
    m_reset();
    reset = 1'b0;
    MEM_MemRead_In = 1'b1; MEM_MemWrite_In = 1'b1; MEM_MemtoReg_In = 1'b0;
    MEM_RegWrite_In = 1'b1; MEM_Zero_In = 1'b0; MEM_Branch_In = 2'b00;
    MEM_ALUresult_In = 32'h1234; MEM_ReadData2_In = 32'h5678;
    MEM_WriteRegister_In = 5'd7; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state: WB cleared, requests suppressed, memory bus follows inputs
    chk_wb("rst");
    chk("rst_err",   32'(mem_err), 32'd0);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall),   32'd0);
    chk("rst_we",    32'(mem_we),  32'd1);
    chk("rst_addr",  mem_addr,     32'h1234);
    reset = 1'b1;

    // Zero-wait load
    run_instr("ld0", 1, 0, 1, 1, 0, 2'b00, 32'h10, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    chk("ld0_data", WB_ReadData_Out, 32'hDEADBEEF);
    chk("ld0_rw",   32'(WB_RegWrite_Out), 32'd1);

    // Three-wait store
    stall_seen = 0;
    run_instr("st3", 0, 1, 0, 0, 0, 2'b00, 32'h20, 32'hCAFEF00D, 5'd0, 3, 32'h0);
    chk("st3_stalls", 32'(stall_seen), 32'd3);

    // Branches
    run_instr("br01", 0, 0, 0, 0, 1, 2'b01, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    chk("br01_z1", 32'(PCSrc), 32'd1);
    run_instr("br10", 0, 0, 0, 0, 1, 2'b10, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    chk("br10_z1", 32'(PCSrc), 32'd0);
    run_instr("br11", 0, 0, 0, 0, 0, 2'b11, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    chk("br11_z0", 32'(PCSrc), 32'd0);

    // Back-to-back one-wait loads
    run_instr("bb1", 1, 0, 1, 1, 0, 2'b00, 32'h40, 32'h0, 5'd4, 1, 32'h11111111);
    chk("bb1_data", WB_ReadData_Out, 32'h11111111);
    run_instr("bb2", 1, 0, 1, 1, 0, 2'b00, 32'h44, 32'h0, 5'd5, 1, 32'h22222222);
    chk("bb2_data", WB_ReadData_Out, 32'h22222222);

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 3);
      run_instr("rnd", op[0], op[1], 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), $urandom, $urandom, 5'($urandom),
                $urandom_range(0, 4), $urandom);
    end

    // Reset in the middle of a wait (wcnt reaches 5)
    MEM_MemRead_In = 1; MEM_MemWrite_In = 0; MEM_RegWrite_In = 1;
    MEM_MemtoReg_In = 1; MEM_Branch_In = 2'b00; mem_ready = 0;
    for (int i = 0; i < 5; i++) do_cycle("mid");
    #2 reset = 1'b0;
    #1;
    chk("mid_stall", 32'(stall),   32'd0);
    chk("mid_req",   32'(mem_req), 32'd0);
    chk("mid_err",   32'(mem_err), 32'd0);
    m_reset();
    chk_wb("mid");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_instr("mid_rd", 1, 0, 1, 1, 0, 2'b00, 32'h80, 32'h0, 5'd9, 1, 32'hA5A5A5A5);
    chk("mid_rd_data", WB_ReadData_Out, 32'hA5A5A5A5);

    // Timeout
    stall_seen = 0;
    run_instr("to", 1, 0, 1, 1, 0, 2'b00, 32'h90, 32'h0, 5'd2, 999, 32'h0);
    chk("to_stalls", 32'(stall_seen), 32'd15);
    chk("to_err",    32'(mem_err),    32'd1);
    run_instr("post", 1, 0, 1, 1, 0, 2'b00, 32'h94, 32'h0, 5'd6, 0, 32'h77777777);
    chk("post_req", 32'(mem_req), 32'd0);
    run_instr("post_st", 0, 1, 0, 1, 0, 2'b00, 32'h98, 32'h1, 5'd8, 0, 32'h0);
    chk("post_st_req", 32'(mem_req), 32'd0);
    chk("post_st_rw",  32'(WB_RegWrite_Out), 32'd1);

    // Reset clears the sticky error and the WB register
    reset = 1'b0;
    #1;
    chk("clr_err", 32'(mem_err),         32'd0);
    chk("clr_rw",  32'(WB_RegWrite_Out), 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    run_instr("clr_rd", 1, 0, 1, 1, 0, 2'b00, 32'hA0, 32'h0, 5'd1, 2, 32'h0BADF00D);
    chk("clr_rd_data", WB_ReadData_Out, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MEM_MemWrite_In, MEM_MemRead_In, MEM_MemtoReg_In, MEM_RegWrite_In, MEM_Zero_In  in  1 each  control/flag fields from the EX/MEM pipeline register.
- MEM_Branch_In  in  2  branch type: 00 none, 01 beq, 10 bne, 11 reserved.
- MEM_ALUresult_In  in  32  ALU result and data-memory byte address.
- MEM_ReadData2_In  in  32  store data.
- MEM_WriteRegister_In  in  5  destination register.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current request.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  branch taken.
- mem_err  out  1  sticky timeout flag.
- WB_RegWrite_Out, WB_MemtoReg_Out  out  1 each  registered control to WB.
- WB_ReadData_Out, WB_ALUresult_Out  out  32 each  registered data to WB.
- WB_WriteRegister_Out  out  5  registered destination to WB.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum wait cycles per access (range 2..255).

Function
REQ-003 An access SHALL be pending when (MEM_MemRead_In | MEM_MemWrite_In) and mem_err is 0; if both are set, the access SHALL be treated as a write.
REQ-004 mem_req SHALL equal "access pending", combinationally.
REQ-005 Memory signals SHALL be driven combinationally: mem_we = MEM_MemWrite_In, mem_addr = MEM_ALUresult_In, mem_wdata = MEM_ReadData2_In.
REQ-006 The FSM SHALL have two states, IDLE and WAIT, plus an 8-bit wait counter wcnt.
REQ-007 In IDLE with an access pending and mem_ready=0, the next state SHALL be WAIT with wcnt=1.
REQ-008 In IDLE with an access pending and mem_ready=1, the access SHALL be a zero-wait access: no stall, FSM stays in IDLE.
REQ-009 In WAIT, mem_ready=1 SHALL complete the access; next state IDLE, wcnt=0.
REQ-010 In WAIT with mem_ready=0, wcnt SHALL increment each cycle.
REQ-011 In WAIT with mem_ready=0 and wcnt = TIMEOUT-1, the access SHALL abort: mem_err set to 1, next state IDLE, wcnt=0.
REQ-012 stall SHALL equal (access pending & ~mem_ready & ~abort_this_cycle), combinationally.
REQ-013 mem_err SHALL remain set until reset; while it is set, no further accesses SHALL be issued (mem_req=0, stall=0).
REQ-014 PCSrc SHALL be (Branch==01 & Zero) | (Branch==10 & ~Zero), combinationally; Branch=11 SHALL give 0.
REQ-015 On a rising clk edge with stall=0, the WB registers SHALL capture RegWrite, MemtoReg, ALUresult and WriteRegister from the inputs.
REQ-016 On such an edge, WB_ReadData_Out SHALL capture mem_rdata for a read completed by mem_ready, and 0 otherwise.
REQ-017 On an aborted access, the WB registers SHALL load a bubble: RegWrite=0, all other fields 0.
REQ-018 On a rising clk edge with stall=1, the WB registers SHALL load a bubble (WB_RegWrite_Out=0) so the stalled instruction writes back exactly once.
REQ-019 Latency: a zero-wait access SHALL reach WB one edge after arrival; an N-wait access SHALL reach WB N+1 edges after arrival.

Reset
REQ-020 reset=0 SHALL immediately and asynchronously force all WB_* outputs to 0, mem_err to 0, the FSM to IDLE and wcnt to 0, including mid-access.
REQ-021 Combinational outputs SHALL follow their inputs during reset, except that mem_req and stall SHALL be forced to 0.

Verification
REQ-022 Zero-wait load: MemRead=1, addr=0x10, mem_ready=1, mem_rdata=0xDEADBEEF -> stall stays 0; next edge WB_ReadData_Out=0xDEADBEEF, WB_RegWrite_Out=1.
REQ-023 Three-wait store: MemWrite=1, mem_ready rises on the 4th cycle -> stall=1 for 3 cycles; WB_RegWrite_Out=0 during the stall; mem_we=1 throughout.
REQ-024 Timeout: read with mem_ready held at 0 and TIMEOUT=16 -> stall=1 for 15 cycles; mem_err=1 after the 16th edge; mem_req=0 for all later accesses.
REQ-025 Branch: Branch=01 with Zero=1 -> PCSrc=1; Branch=10 with Zero=1 -> PCSrc=0; Branch=11 -> PCSrc=0.
REQ-026 Reset mid-wait: reset=0 in WAIT with wcnt=5 -> immediately stall=0, WB_* = 0, mem_err=0; after release a new read completes normally.
REQ-027 Back-to-back loads, each with 1 wait cycle -> each load produces exactly one WB_RegWrite_Out=1 cycle, carrying the correct data in order.
